// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and register-file constants
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic [31:0] WB_COUNT_MAX = 32'hFFFF_FFFF;

endpackage : cpu_pkg

// File: rtl/wb_mux.sv
// rtl/wb_mux.sv - 2:1 writeback select between ALU result and load data
module wb_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] wb_data
);

  // Load data wins when the instruction came from memory, otherwise the ALU result
  always_comb begin
    wb_data = mem_to_reg ? read_data : alu_out;
  end

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - register file with writeback select, write-through bypass and write counter
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [DATA_W-1:0]     ALUOut,
  input  logic [DATA_W-1:0]     ReadData,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic [DATA_W-1:0]     WB_Data,
  output logic [31:0]           WB_Count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [31:0]       count_q;
  logic [31:0]       count_d;
  logic              write_en;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .mem_to_reg (MemtoReg),
    .alu_out    (ALUOut),
    .read_data  (ReadData),
    .wb_data    (WB_Data)
  );

  // A write only takes effect outside reset and never to the hardwired zero register
  always_comb begin
    write_en = RegWrite && (WriteReg != REG_ZERO) && !RESET;
  end

  // Read ports: zero register and reset read 0, a same-cycle write is bypassed through
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!RESET && (ReadReg1 != REG_ZERO)) begin
      ReadData1 = (write_en && (ReadReg1 == WriteReg)) ? WB_Data : regs_q[ReadReg1];
    end
    if (!RESET && (ReadReg2 != REG_ZERO)) begin
      ReadData2 = (write_en && (ReadReg2 == WriteReg)) ? WB_Data : regs_q[ReadReg2];
    end
  end

  // Next register state and saturating count of effective writes
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (write_en) begin
      regs_d[WriteReg] = WB_Data;
      if (count_q != WB_COUNT_MAX) begin
        count_d = count_q + 32'd1;
      end
    end
  end

  // Storage and counter, cleared immediately on reset
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      regs_q  <= '{default: '0};
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign WB_Count = count_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        CLOCK;
  logic        RESET;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ALUOut;
  logic [31:0] ReadData;
  logic [4:0]  WriteReg;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WB_Data;
  logic [31:0] WB_Count;

  int err_cnt = 0;
  int chk_cnt = 0;

  wb_regfile dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .RegWrite  (RegWrite),
    .MemtoReg  (MemtoReg),
    .ALUOut    (ALUOut),
    .ReadData  (ReadData),
    .WriteReg  (WriteReg),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .WB_Data   (WB_Data),
    .WB_Count  (WB_Count)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
    RegWrite = 1'b1;
    MemtoReg = 1'b0;
    ALUOut   = val;
    WriteReg = idx;
    tick();
    RegWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    RESET    = 1'b1;
    RegWrite = 1'b1;
    MemtoReg = 1'b0;
    ALUOut   = 32'h0000_0011;
    ReadData = 32'h0000_0022;
    WriteReg = 5'd5;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd5;
    #2;
    check("reset_rd1_no_bypass", ReadData1, 32'h0);
    check("reset_rd2_no_bypass", ReadData2, 32'h0);
    check("reset_count", WB_Count, 32'h0);
    check("reset_wbdata_alu", WB_Data, 32'h0000_0011);
    tick();
    tick();
    check("reset_hold_count", WB_Count, 32'h0);
    RESET    = 1'b0;
    RegWrite = 1'b0;

    // Mux selects by MemtoReg regardless of RegWrite
    MemtoReg = 1'b1;
    #1;
    check("wbdata_mem", WB_Data, 32'h0000_0022);

    // Basic ALU write to reg 5, bypass before the edge
    RegWrite = 1'b1;
    MemtoReg = 1'b0;
    ALUOut   = 32'h0000_00AA;
    WriteReg = 5'd5;
    ReadReg1 = 5'd5;
    #1;
    check("bypass_r5", ReadData1, 32'h0000_00AA);
    tick();
    RegWrite = 1'b0;
    ALUOut   = 32'h0;
    #1;
    check("r5_after_write", ReadData1, 32'h0000_00AA);
    check("count_1", WB_Count, 32'd1);

    // Load write to reg 7, both ports bypass
    RegWrite = 1'b1;
    MemtoReg = 1'b1;
    ReadData = 32'hDEAD_BEEF;
    WriteReg = 5'd7;
    ReadReg1 = 5'd7;
    ReadReg2 = 5'd7;
    #1;
    check("bypass_p1_r7", ReadData1, 32'hDEAD_BEEF);
    check("bypass_p2_r7", ReadData2, 32'hDEAD_BEEF);
    tick();
    RegWrite = 1'b0;
    ReadData = 32'h0;
    #1;
    check("p1_r7_stored", ReadData1, 32'hDEAD_BEEF);
    check("p2_r7_stored", ReadData2, 32'hDEAD_BEEF);
    check("count_2", WB_Count, 32'd2);

    // Writes to reg 0 are dropped and uncounted
    RegWrite = 1'b1;
    MemtoReg = 1'b0;
    ALUOut   = 32'h1234_5678;
    WriteReg = 5'd0;
    ReadReg1 = 5'd0;
    #1;
    check("r0_no_bypass", ReadData1, 32'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("r0_reads_zero", ReadData1, 32'h0);
    check("count_r0_unchanged", WB_Count, 32'd2);

    // RegWrite=0 holds state for several edges
    do_write(5'd3, 32'h0000_0055);
    WriteReg = 5'd3;
    ALUOut   = 32'h0000_0099;
    MemtoReg = 1'b0;
    ReadReg2 = 5'd3;
    #1;
    check("r3_no_bypass_when_idle", ReadData2, 32'h0000_0055);
    for (int i = 0; i < 4; i++) tick();
    check("r3_held", ReadData2, 32'h0000_0055);
    check("count_3_held", WB_Count, 32'd3);
    ReadReg1 = 5'd5;
    #1;
    check("r5_untouched", ReadData1, 32'h0000_00AA);

    // Async reset between edges clears immediately
    do_write(5'd9, 32'h0000_0077);
    ReadReg1 = 5'd9;
    #1;
    check("r9_written", ReadData1, 32'h0000_0077);
    check("count_4", WB_Count, 32'd4);
    #1;
    RESET = 1'b1;
    #1;
    check("r9_cleared_async", ReadData1, 32'h0);
    check("count_cleared_async", WB_Count, 32'h0);
    RESET = 1'b0;
    ReadReg2 = 5'd5;
    #1;
    check("r9_after_reset", ReadData1, 32'h0);
    check("r5_after_reset", ReadData2, 32'h0);

    // Write coinciding with reset assertion is lost
    RegWrite = 1'b1;
    MemtoReg = 1'b0;
    ALUOut   = 32'h0000_0044;
    WriteReg = 5'd4;
    @(posedge CLOCK);
    RESET = 1'b1;
    #1;
    RegWrite = 1'b0;
    #2;
    RESET    = 1'b0;
    ReadReg1 = 5'd4;
    #1;
    check("r4_lost_at_reset", ReadData1, 32'h0);
    check("count_lost_at_reset", WB_Count, 32'h0);

    // First edge after reset release writes
    do_write(5'd6, 32'h0000_0066);
    ReadReg1 = 5'd6;
    #1;
    check("r6_first_after_reset", ReadData1, 32'h0000_0066);
    check("count_first_after_reset", WB_Count, 32'd1);

    // Counter saturation
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    #1;
    check("count_preload", WB_Count, 32'hFFFF_FFFE);
    do_write(5'd10, 32'h0000_0001);
    check("count_sat_step1", WB_Count, 32'hFFFF_FFFF);
    do_write(5'd11, 32'h0000_0002);
    check("count_sat_step2", WB_Count, 32'hFFFF_FFFF);
    do_write(5'd12, 32'h0000_0003);
    check("count_sat_step3", WB_Count, 32'hFFFF_FFFF);
    ReadReg1 = 5'd12;
    #1;
    check("r12_written", ReadData1, 32'h0000_0003);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_wb_regfile
